// File: rtl/ds_mod2.sv
// Second-order 1-bit delta-sigma modulator with integrator saturation and a
// run-length overload detector that clears the loop and plays an idle toggle pattern.
module ds_mod2 #(
  parameter int unsigned IN_W        = 20,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned OVL_LIMIT   = 16,
  parameter int unsigned RECOVER_CYC = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic [IN_W-1:0] x_in,
  input  logic            ovl_clr,
  output logic            ds_o,
  output logic            ovl_o,
  output logic [7:0]      ovl_cnt
);

  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] FS      = SUM_W'(1) << (IN_W - 1);
  localparam logic signed [SUM_W-1:0] ACC_MAX = (SUM_W'(1) << (ACC_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -(SUM_W'(1) << (ACC_W - 1));

  typedef enum logic [1:0] {
    ST_RUN,
    ST_CLEAR,
    ST_RECOVER
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic                    ds_q, ds_d;
  logic [7:0]              run_len_q, run_len_d;
  logic [7:0]              rec_cnt_q, rec_cnt_d;
  logic [7:0]              ovl_cnt_q, ovl_cnt_d;

  logic signed [SUM_W-1:0] fb;
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] i1_ext;
  logic signed [SUM_W-1:0] i2_ext;
  logic signed [SUM_W-1:0] step1;
  logic signed [SUM_W-1:0] step2;
  logic signed [ACC_W-1:0] i1_run;
  logic signed [ACC_W-1:0] i2_run;
  logic                    ds_run;
  logic [7:0]              run_len_run;
  logic                    ovl_hit;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (v > ACC_MAX) begin
      return ACC_MAX[ACC_W-1:0];
    end else if (v < ACC_MIN) begin
      return ACC_MIN[ACC_W-1:0];
    end
    return v[ACC_W-1:0];
  endfunction

  // Loop datapath: both integrators use the old feedback bit; i2 sees the old i1.
  always_comb begin
    fb          = ds_q ? FS : -FS;
    x_ext       = {{(SUM_W-IN_W){x_in[IN_W-1]}}, x_in};
    i1_ext      = {{2{i1_q[ACC_W-1]}}, i1_q};
    i2_ext      = {{2{i2_q[ACC_W-1]}}, i2_q};
    step1       = (x_ext - fb) >>> 1;
    step2       = (i1_ext - fb) >>> 1;
    i1_run      = sat_acc(i1_ext + step1);
    i2_run      = sat_acc(i2_ext + step2);
    ds_run      = ~i2_run[ACC_W-1];
    if (ds_run != ds_q) begin
      run_len_run = 8'd1;
    end else if (run_len_q == 8'd255) begin
      run_len_run = 8'd255;
    end else begin
      run_len_run = run_len_q + 8'd1;
    end
    ovl_hit     = (state_q == ST_RUN) && (run_len_run == 8'(OVL_LIMIT));
  end

  always_comb begin
    state_d   = state_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    ds_d      = ds_q;
    run_len_d = run_len_q;
    rec_cnt_d = rec_cnt_q;
    ovl_cnt_d = ovl_cnt_q;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          i1_d      = i1_run;
          i2_d      = i2_run;
          ds_d      = ds_run;
          run_len_d = run_len_run;
          if (ovl_hit) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          i1_d      = '0;
          i2_d      = '0;
          ds_d      = 1'b0;
          rec_cnt_d = '0;
          state_d   = ST_RECOVER;
        end
        ST_RECOVER: begin
          i1_d      = '0;
          i2_d      = '0;
          ds_d      = ~ds_q;
          rec_cnt_d = rec_cnt_q + 8'd1;
          if (rec_cnt_q == 8'(RECOVER_CYC - 1)) begin
            state_d   = ST_RUN;
            run_len_d = 8'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
      // A clear coinciding with a new event still records that event.
      if (ovl_clr) begin
        ovl_cnt_d = ovl_hit ? 8'd1 : 8'd0;
      end else if (ovl_hit && (ovl_cnt_q != 8'd255)) begin
        ovl_cnt_d = ovl_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      i1_q      <= '0;
      i2_q      <= '0;
      ds_q      <= 1'b0;
      run_len_q <= 8'd1;
      rec_cnt_q <= '0;
      ovl_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      ds_q      <= ds_d;
      run_len_q <= run_len_d;
      rec_cnt_q <= rec_cnt_d;
      ovl_cnt_q <= ovl_cnt_d;
    end
  end

  assign ds_o    = ds_q;
  assign ovl_o   = (state_q != ST_RUN);
  assign ovl_cnt = ovl_cnt_q;

endmodule
